// File: rtl/text_receiver.sv
// Recovers STX/text/ETX/CHK framed messages from a byte stream and writes the text plus a 0x00 terminator into a text RAM.
// Latency: one Clk from the sampling Clk_Ena to the RAM write and to Frame_Done/Frame_Error/Length.
// Backpressure: none; bytes arrive on Clk_Ena and are always consumed, and all state holds while Clk_Ena is low.
module text_receiver #(
    parameter logic [7:0] STX        = 8'h02,
    parameter logic [7:0] ETX        = 8'h03,
    parameter int         Max_Length = 1023
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Clk_Ena,
    input  logic [7:0] Stream,
    output logic [9:0] Address,
    output logic [7:0] Data,
    output logic       Write_Enable,
    output logic [9:0] Length,
    output logic       Frame_Done,
    output logic       Frame_Error
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TEXT  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [9:0] MAX_LEN = Max_Length[9:0];

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [9:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       we_q, we_d;
    logic [9:0] len_q, len_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            sum_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (Clk_Ena) begin
            unique case (state_q)
                HUNT: begin
                    if (Stream == STX) begin
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = TEXT;
                    end
                end
                TEXT: begin
                    if (Stream == ETX) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q;
                        data_d  = 8'h00;
                        state_d = CHECK;
                    end else if (Stream == STX) begin
                        // Resync: restart the frame, earlier RAM contents are simply overwritten later.
                        cnt_d = '0;
                        sum_d = '0;
                    end else if (cnt_q < MAX_LEN) begin
                        we_d   = 1'b1;
                        addr_d = cnt_q;
                        data_d = Stream;
                        sum_d  = sum_q + Stream;
                        cnt_d  = cnt_q + 10'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
                CHECK: begin
                    if (Stream == sum_q) begin
                        done_d = 1'b1;
                        len_d  = cnt_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign Address      = addr_q;
    assign Data         = data_q;
    assign Write_Enable = we_q;
    assign Length       = len_q;
    assign Frame_Done   = done_q;
    assign Frame_Error  = err_q;

endmodule

// File: tb/tb_text_receiver.sv
// Directed bench for text_receiver: expected RAM writes are queued as bytes are sent and popped by a write monitor.
module tb_text_receiver;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Clk_Ena;
    logic [7:0] Stream;
    logic [9:0] Address;
    logic [7:0] Data;
    logic       Write_Enable;
    logic [9:0] Length;
    logic       Frame_Done;
    logic       Frame_Error;

    text_receiver dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Clk_Ena      (Clk_Ena),
        .Stream       (Stream),
        .Address      (Address),
        .Data         (Data),
        .Write_Enable (Write_Enable),
        .Length       (Length),
        .Frame_Done   (Frame_Done),
        .Frame_Error  (Frame_Error)
    );

    always #5 Clk = ~Clk;

    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         done0, err0;
    logic [9:0] len_at_done = '0;
    logic [17:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write/pulse monitor, sampling on the falling edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Write_Enable) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", Address, Data);
                end else begin
                    logic [17:0] e;
                    e = wq.pop_front();
                    tests++;
                    assert ({Address, Data} === e) else begin
                        fails++;
                        $error("FAIL ram_write: observed addr %0h data %0h expected addr %0h data %0h",
                               Address, Data, e[17:8], e[7:0]);
                    end
                end
            end
            if (Frame_Done) begin
                done_cnt++;
                len_at_done = Length;
            end
            if (Frame_Error) err_cnt++;
            if (Frame_Done || Frame_Error) begin
                tests++;
                assert (!(Frame_Done && Frame_Error)) else begin
                    fails++;
                    $error("FAIL pulse_exclusive: observed done=1 err=1 expected at most one");
                end
            end
        end
    end

    // One byte per 4 Clk: Clk_Ena high for one cycle, then three idle cycles.
    task automatic send(input logic [7:0] b);
        Stream  = b;
        Clk_Ena = 1'b1;
        @(negedge Clk);
        Clk_Ena = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic exp_wr(input logic [9:0] a, input logic [7:0] d);
        wq.push_back({a, d});
    endtask

    task automatic frame_start();
        done0 = done_cnt;
        err0  = err_cnt;
    endtask

    task automatic frame_end(input string tag, input int ed, input int ee, input logic [9:0] elen);
        chk({tag, "_done"}, done_cnt - done0, ed);
        chk({tag, "_err"}, err_cnt - err0, ee);
        chk({tag, "_len"}, Length, elen);
        chk({tag, "_wq_empty"}, wq.size(), 0);
    endtask

    initial begin
        Reset   = 1'b1;
        Clk_Ena = 1'b0;
        Stream  = 8'h00;
        @(negedge Clk);
        chk("rst_addr", Address, 0);
        chk("rst_data", Data, 0);
        chk("rst_we", Write_Enable, 0);
        chk("rst_len", Length, 0);
        chk("rst_done", Frame_Done, 0);
        chk("rst_err", Frame_Error, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Good frame
        frame_start();
        exp_wr(0, 8'h48); exp_wr(1, 8'h69); exp_wr(2, 8'h00);
        send(8'h02); send(8'h48); send(8'h69); send(8'h03); send(8'hB1);
        frame_end("good", 1, 0, 10'd2);
        chk("good_len_at_done", len_at_done, 2);

        // Bad checksum keeps prior Length
        frame_start();
        exp_wr(0, 8'h41); exp_wr(1, 8'h00);
        send(8'h02); send(8'h41); send(8'h03); send(8'h00);
        frame_end("badchk", 0, 1, 10'd2);

        // Leading garbage and resync
        frame_start();
        exp_wr(0, 8'h41); exp_wr(0, 8'h42); exp_wr(1, 8'h00);
        send(8'hFF); send(8'h03); send(8'h41); send(8'h02); send(8'h41);
        send(8'h02); send(8'h42); send(8'h03); send(8'h42);
        frame_end("resync", 1, 0, 10'd1);
        chk("resync_len_at_done", len_at_done, 1);

        // Empty frame
        frame_start();
        exp_wr(0, 8'h00);
        send(8'h02); send(8'h03); send(8'h00);
        frame_end("empty", 1, 0, 10'd0);

        // Overflow: 1024 text bytes, only 1023 written, no terminator
        frame_start();
        for (int i = 0; i < 1023; i++) exp_wr(i[9:0], 8'h41);
        send(8'h02);
        for (int i = 0; i < 1024; i++) send(8'h41);
        frame_end("overflow", 0, 1, 10'd0);

        // Valid frame after overflow
        frame_start();
        exp_wr(0, 8'h48); exp_wr(1, 8'h69); exp_wr(2, 8'h00);
        send(8'h02); send(8'h48); send(8'h69); send(8'h03); send(8'hB1);
        frame_end("after_ovf", 1, 0, 10'd2);

        // Clk_Ena gating: nothing may happen, and the receiver must still be hunting afterwards
        frame_start();
        Clk_Ena = 1'b0;
        Stream  = 8'h02;
        repeat (40) @(negedge Clk);
        Stream  = 8'h41;
        repeat (40) @(negedge Clk);
        send(8'h41); send(8'h03); send(8'h00);
        frame_end("gating", 0, 0, 10'd2);

        // Reset mid-frame
        frame_start();
        exp_wr(0, 8'h41); exp_wr(1, 8'h42);
        send(8'h02); send(8'h41); send(8'h42);
        chk("midrst_pre_addr", Address, 1);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_addr", Address, 0);
        chk("midrst_data", Data, 0);
        chk("midrst_we", Write_Enable, 0);
        chk("midrst_len", Length, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        send(8'h03); send(8'h00);
        frame_end("midrst", 0, 0, 10'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
